// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier family: FSM state encoding
// and default sizing constants.
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_t;

    localparam int BCD_LIMIT     = 9;
    localparam int MUL_W_DEFAULT = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, the building block for the ripple-carry adders.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/ripple_add_w.sv
// WIDTH-bit ripple-carry adder (no carry in, carry out) chained from
// full_adder cells; used for the partial-product accumulate.
module ripple_add_w #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .x    (a[i]),
            .y    (b[i]),
            .cin  (carry[i]),
            .s    (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mul_nxn.sv
// Shift-add unsigned multiplier: WIDTH steps per product, start/busy/done
// handshake, optional operand range check that zeroes the result and flags err.
module seq_mul_nxn
    import mul_pkg::*;
#(
    parameter int WIDTH    = MUL_W_DEFAULT,
    parameter int LIMIT_EN = 1,
    parameter int LIMIT    = BCD_LIMIT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y,
    output logic               err
);

    localparam int          CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [31:0] LIMIT_U = LIMIT;

    mul_state_t         state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;
    logic [2*WIDTH-1:0] p_next;
    logic [WIDTH-1:0]   a_reg;
    logic               bad;
    logic               bad_in;
    logic               load;
    logic               last;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     hi_next;

    assign bad_in = (LIMIT_EN != 0) && ((32'(a) > LIMIT_U) || (32'(b) > LIMIT_U));

    ripple_add_w #(.WIDTH(WIDTH)) u_add (
        .a    (p[2*WIDTH-1:WIDTH]),
        .b    (a_reg),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // The carry lands in the top bit so the shift never loses it.
    assign hi_next = p[0] ? {add_cout, add_sum} : {1'b0, p[2*WIDTH-1:WIDTH]};
    assign p_next  = {hi_next, p[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        last    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    last    = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_n = ST_RUN;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs only move on DONE entry, so y/err stay stable through RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            p     <= '0;
            a_reg <= '0;
            bad   <= 1'b0;
            y     <= '0;
            err   <= 1'b0;
        end else if (load) begin
            cnt   <= '0;
            p     <= {{WIDTH{1'b0}}, b};
            a_reg <= a;
            bad   <= bad_in;
        end else if (state == ST_RUN) begin
            p   <= p_next;
            cnt <= cnt + CW'(1);
            if (last) begin
                y   <= bad ? '0 : p_next;
                err <= bad;
            end
        end
    end

endmodule

// File: tb/tb_seq_mul_nxn.sv
// Directed self-checking bench for seq_mul_nxn: default BCD instance plus an
// 8-bit instance with the range check disabled.
module tb_seq_mul_nxn;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  a, b;
    logic        busy, done, err;
    logic [7:0]  y;

    logic        start8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, err8;
    logic [15:0] y8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mul_nxn dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .y(y), .err(err)
    );

    seq_mul_nxn #(.WIDTH(8), .LIMIT_EN(0), .LIMIT(9)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .y(y8), .err(err8)
    );

    // Drives one start pulse; returns in the first RUN cycle.
    task automatic applyStimulus(input logic [3:0] va, input logic [3:0] vb);
        start = 1'b1; a = va; b = vb;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks the 4-cycle RUN window then the single DONE cycle and result.
    task automatic run_and_check(input string name, input logic [7:0] exp_y, input logic exp_err);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s run%0d busy=%b done=%b expected busy=1 done=0", name, i, busy, done);
            end
            @(negedge clk);
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || y !== exp_y || err !== exp_err) begin
            errors++;
            $display("[TB] FAIL %s result done=%b busy=%b y=%0d err=%b expected done=1 busy=0 y=%0d err=%b",
                     name, done, busy, y, err, exp_y, exp_err);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s pulse done=%b expected 0", name, done);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; a = 4'd3; b = 4'd3;
        start8 = 1'b0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset busy=%b done=%b y=%0d err=%b expected all 0", busy, done, y, err);
        end
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || y8 !== 16'd0 || err8 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset8 busy=%b done=%b y=%0d err=%b expected all 0", busy8, done8, y8, err8);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        applyStimulus(4'd9, 4'd9);
        run_and_check("basic_9x9", 8'h51, 1'b0);
    endtask

    task automatic test_zero;
        applyStimulus(4'd0, 4'd7);
        run_and_check("zero_a", 8'd0, 1'b0);
        applyStimulus(4'd7, 4'd0);
        run_and_check("zero_b", 8'd0, 1'b0);
    endtask

    task automatic test_range;
        applyStimulus(4'd12, 4'd3);
        run_and_check("range_bad", 8'd0, 1'b1);
        applyStimulus(4'd3, 4'd3);
        checks++;
        if (y !== 8'd0 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL range_hold y=%0d err=%b expected y=0 err=1", y, err);
        end
        run_and_check("range_clear", 8'd9, 1'b0);
    endtask

    task automatic test_width8;
        logic [7:0] va [2];
        logic [7:0] vb [2];
        logic [15:0] ve [2];
        va[0] = 8'd255; vb[0] = 8'd255; ve[0] = 16'hFE01;
        va[1] = 8'd128; vb[1] = 8'd2;   ve[1] = 16'd256;
        for (int t = 0; t < 2; t++) begin
            start8 = 1'b1; a8 = va[t]; b8 = vb[t];
            @(negedge clk);
            start8 = 1'b0;
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (busy8 !== 1'b1 || done8 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL w8_run%0d_%0d busy=%b done=%b expected busy=1 done=0", t, i, busy8, done8);
                end
                @(negedge clk);
            end
            checks++;
            if (done8 !== 1'b1 || y8 !== ve[t] || err8 !== 1'b0) begin
                errors++;
                $display("[TB] FAIL w8_result%0d done=%b y=%h err=%b expected done=1 y=%h err=0",
                         t, done8, y8, err8, ve[t]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        start = 1'b1; a = 4'd2; b = 4'd3;
        @(negedge clk);
        a = 4'd7; b = 4'd8;
        repeat (3) @(negedge clk);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || y !== 8'd6 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_first done=%b y=%0d err=%b expected done=1 y=6 err=0", done, y, err);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || y !== 8'd6) begin
            errors++;
            $display("[TB] FAIL b2b_accept busy=%b done=%b y=%0d expected busy=1 done=0 y=6", busy, done, y);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_run busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || y !== 8'd56 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_second done=%b y=%0d err=%b expected done=1 y=56 err=0", done, y, err);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        int pulses;
        applyStimulus(4'd4, 4'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || y !== 8'd0 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort busy=%b done=%b y=%0d err=%b expected all 0", busy, done, y, err);
        end
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("[TB] FAIL abort_quiet active_cycles=%0d expected 0", pulses);
        end
        applyStimulus(4'd5, 4'd6);
        run_and_check("after_abort", 8'd30, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        start8 = 1'b0; a8 = '0; b8 = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero();
        test_range();
        test_width8();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
